bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential decimal-to-binary converter: accepts a three-digit BCD number (hundreds, tens, ones) and produces its 8-bit binary value by iterative reverse double-dabble (shift right, subtract-3 correction), one bit per clock. It is the inverse of the score/register BCD display path. It feeds decimal values entered by the user (keypad digit entry, debug console) back into the CPU datapath as bytes. A start/busy/done handshake lets a controller FSM launch it and wait.

## Interface

Parameters: none.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request conversion; sampled only when `ready` is high
- a  in  2  hundreds digit (0–2 legal)
- b  in  4  tens digit (0–9 legal)
- c  in  4  ones digit (0–9 legal)
- ready  out  1  block can accept `start` this cycle
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: `value`/`err` updated this cycle
- value  out  8  binary result; holds until next completion
- err  out  1  input out of range (only with `BCD_TO_BIN_CHECK_EN`)

## Operation

- State machine: IDLE, SHIFT, DONE.
  - IDLE: `ready`=1. On `start`, capture {a,b,c} into a 12-bit BCD shift register (hundreds zero-extended to 4 bits) and clear the 8-bit binary register and the 3-bit counter. Go to SHIFT.
  - SHIFT: each cycle, shift {bcd[11:0], bin[7:0]} right by one. Then, in each of the three BCD nibbles, any nibble value ≥ 8 is reduced by 3. Counter increments. After the 8th shift, load `value` from bin and go to DONE.
  - DONE: `done`=1 and `ready`=1 for exactly one cycle. `start` here is accepted exactly as in IDLE, and the next state is SHIFT. Otherwise the next state is IDLE.
- Inputs a/b/c are only sampled at the accepting edge; they may change freely while busy.
- Arithmetic: for legal digits, `value` = (100·a + 10·b + c) mod 256.
- `start` while busy: ignored, no side effects.
- Reset (any state, including mid-SHIFT): state=IDLE, busy=0, done=0, ready=1, value=0x00, err=0, counter=0. The in-flight conversion is discarded with no `done` pulse.

## Timing

- Cycle 0: `start`=1 with `ready`=1.
- Cycles 1–8: `busy`=1, `ready`=0, `done`=0.
- Cycle 9: `done`=1, `busy`=0, `ready`=1, `value`/`err` valid.
- Latency is fixed at 9 cycles from the accept cycle to `done`. Throughput is one conversion per 9 cycles when `start` is held high.
- `ready` = IDLE or DONE. `busy` = SHIFT. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration

- `BCD_TO_BIN_CHECK_EN` defined:
  - At accept, the block computes an error flag, registers it, and presents it as `err` at `done`.
  - The flag is set when any of the following hold: a = 3; b > 9; c > 9; or a = 2 with 10·b + c > 55 (value > 255).
  - When the flag is set, `value` = 0xFF (saturate) and `err` = 1. Otherwise `err` = 0.
- `BCD_TO_BIN_CHECK_EN` undefined:
  - `err` is tied to 0 and no check logic is present.
  - Legal digits give the mod-256 result.
  - Illegal digits (a = 3, b > 9, c > 9) give an unspecified but deterministic `value`.

## Test plan

- Reset, then a=2, b=5, c=5, start → `done` in cycle 9 with `value`=0xFF, `err`=0; `busy` high cycles 1–8 exactly.
- Inputs 0/0/0 → `value`=0x00. Inputs 1/2/8 → `value`=0x80. Sweep all 0–255 via the matching decimal digits → `value` equals the number each time.
- `start` held high continuously with 0/4/2 then 0/9/9 changed in the DONE cycle → `done` pulses every 9 cycles, `value` = 0x2A then 0x63. Changing a/b/c during busy does not affect the result.
- `start` pulsed in cycle 4 of a conversion → ignored: exactly one `done`, correct value.
- `reset` asserted in cycle 5 of a conversion → next cycle `busy`=0, `ready`=1, `value`=0x00, no `done`. A new start then converts correctly.
- Inputs 2/5/6 → with `BCD_TO_BIN_CHECK_EN`, `err`=1 and `value`=0xFF; without it, `err`=0 and `value`=0x00. Inputs 0/10/0 with the macro → `err`=1.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential three-digit BCD to 8-bit binary converter.
// Reverse double-dabble: the {bcd, bin} register pair shifts right one bit
// per clock; afterwards every BCD nibble >= 8 is reduced by 3. Eight shifts
// leave the binary value (mod 256) in bin.
//
// Optional feature: define BCD_TO_BIN_CHECK_EN to add an input range check.
// Out-of-range inputs then report err=1 and value=0xFF. Without the macro,
// err is tied to 0 and no check logic exists.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   conversion request, honoured only while ready=1
//   a      in   hundreds digit (2 bits)
//   b      in   tens digit (4 bits)
//   c      in   ones digit (4 bits)
//   ready  out  start is accepted this cycle (IDLE or DONE)
//   busy   out  conversion in progress (SHIFT)
//   done   out  one-cycle pulse, value/err updated
//   value  out  binary result, held until the next completion
//   err    out  input out of range (check build only)
module bcd_to_bin (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] a,
   input  logic [3:0] b,
   input  logic [3:0] c,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] value,
   output logic       err
);

   localparam int unsigned BCD_W = 12;
   localparam int unsigned BIN_W = 8;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   value_q, value_d;

   // One right shift of the concatenated register pair
   logic [BCD_W+BIN_W-1:0] shift_c;
   assign shift_c = {bcd_q, bin_q} >> 1;

   // Subtract-3 correction, undoing the decimal carry that the shift split
   function automatic logic [3:0] fix_nibble(input logic [3:0] n);
      return (n >= 4'd8) ? (n - 4'd3) : n;
   endfunction

`ifdef BCD_TO_BIN_CHECK_EN
   logic flag_q, flag_d;
   logic err_q, err_d;
   logic range_bad_c;

   // a=2 with tens/ones above 55 overflows a byte
   assign range_bad_c = (a == 2'd3) || (b > 4'd9) || (c > 4'd9) ||
                        ((a == 2'd2) && ((b > 4'd5) || ((b == 4'd5) && (c > 4'd5))));
`endif

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      value_d = value_q;
`ifdef BCD_TO_BIN_CHECK_EN
      flag_d  = flag_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               bcd_d   = {2'b00, a, b, c};
               bin_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
`ifdef BCD_TO_BIN_CHECK_EN
               flag_d  = range_bad_c;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            bin_d = shift_c[BIN_W-1:0];
            bcd_d = {fix_nibble(shift_c[19:16]),
                     fix_nibble(shift_c[15:12]),
                     fix_nibble(shift_c[11:8])};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
               state_d = S_DONE;
`ifdef BCD_TO_BIN_CHECK_EN
               value_d = flag_q ? 8'hFF : shift_c[BIN_W-1:0];
               err_d   = flag_q;
`else
               value_d = shift_c[BIN_W-1:0];
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         value_q <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
`ifdef BCD_TO_BIN_CHECK_EN
         flag_q  <= flag_d;
         err_q   <= err_d;
`endif
      end
   end

   // Handshake decoded from the state register only
   assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy  = (state_q == S_SHIFT);
   assign done  = (state_q == S_DONE);
   assign value = value_q;

`ifdef BCD_TO_BIN_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed testbench for bcd_to_bin: timing, arithmetic sweep, back-to-back
// starts, start while busy, mid-conversion reset and the optional range check.
module tb_bcd_to_bin;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] a;
   logic [3:0] b;
   logic [3:0] c;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] value;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;
   int n_done;

   bcd_to_bin dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .value (value),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept at cycle 0, junk inputs while busy, check handshake each cycle,
   // leaves the bench in the DONE cycle (cycle 9).
   task automatic convert(input logic [1:0] ta, input logic [3:0] tb_d, input logic [3:0] tc,
                          input logic [7:0] ev, input logic ee, input bit chk_val);
      check("ready_at_accept", 8'(ready), 8'd1);
      a = ta; b = tb_d; c = tc; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         a = 2'($urandom); b = 4'($urandom); c = 4'($urandom);
         check("busy_ready_done_shift", 8'({busy, ready, done}), 8'b100);
         step();
      end
      check("busy_ready_done_at_done", 8'({busy, ready, done}), 8'b011);
      if (chk_val) check("value", value, ev);
      check("err", 8'(err), 8'(ee));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
      step();
      step();
      check("reset_handshake", 8'({busy, ready, done}), 8'b010);
      check("reset_value", value, 8'h00);
      check("reset_err", 8'(err), 8'd0);
      reset = 1'b0;
      step();

      // Upper boundary and simple vectors
      convert(2'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b1);
      convert(2'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1);
      convert(2'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b1);

      // Full sweep 0..255 via decimal digits
      for (int n = 0; n < 256; n++) begin
         convert(2'(n / 100), 4'((n / 10) % 10), 4'(n % 10), 8'(n), 1'b0, 1'b1);
      end
      step();
      check("idle_after_done", 8'({busy, ready, done}), 8'b010);

      // start held high: back-to-back, inputs swapped in the DONE cycle
      a = 2'd0; b = 4'd4; c = 4'd2; start = 1'b1;
      step();
      for (int i = 1; i <= 8; i++) begin
         a = 2'($urandom); b = 4'($urandom); c = 4'($urandom);
         step();
      end
      check("held_done1", 8'(done), 8'd1);
      check("held_value1", value, 8'h2A);
      a = 2'd0; b = 4'd9; c = 4'd9;
      step();
      for (int i = 1; i <= 8; i++) begin
         check("held_busy2", 8'({busy, done}), 8'b10);
         a = 2'($urandom); b = 4'($urandom); c = 4'($urandom);
         step();
      end
      check("held_done2", 8'(done), 8'd1);
      check("held_value2", value, 8'h63);
      start = 1'b0;
      step();
      check("held_idle", 8'({busy, ready, done}), 8'b010);

      // start pulsed in cycle 4 is ignored
      a = 2'd1; b = 4'd2; c = 4'd8; start = 1'b1;
      step();
      start = 1'b0;
      n_done = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         start = (cyc == 4);
         if (done) n_done++;
         if (cyc == 9) check("ignored_start_value", value, 8'h80);
         step();
      end
      start = 1'b0;
      check("ignored_start_done_count", 8'(n_done), 8'd1);

      // Reset in cycle 5 discards the conversion
      a = 2'd2; b = 4'd5; c = 4'd5; start = 1'b1;
      step();
      start = 1'b0;
      for (int cyc = 1; cyc < 5; cyc++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset_handshake", 8'({busy, ready, done}), 8'b010);
      check("midreset_value", value, 8'h00);
      check("midreset_err", 8'(err), 8'd0);
      n_done = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (done) n_done++;
         step();
      end
      check("midreset_no_done", 8'(n_done), 8'd0);
      convert(2'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b1);

      // Out-of-range inputs
`ifdef BCD_TO_BIN_CHECK_EN
      convert(2'd2, 4'd5, 4'd6, 8'hFF, 1'b1, 1'b1);
      convert(2'd0, 4'd10, 4'd0, 8'hFF, 1'b1, 1'b1);
      convert(2'd3, 4'd0, 4'd0, 8'hFF, 1'b1, 1'b1);
      convert(2'd0, 4'd0, 4'd12, 8'hFF, 1'b1, 1'b1);
      convert(2'd2, 4'd0, 4'd0, 8'hC8, 1'b0, 1'b1);
`else
      convert(2'd2, 4'd5, 4'd6, 8'h00, 1'b0, 1'b1);
      convert(2'd0, 4'd10, 4'd0, 8'h00, 1'b0, 1'b0);
      convert(2'd2, 4'd9, 4'd9, 8'h2B, 1'b0, 1'b1);
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
